keypad_time_loader: RTL and testbench
=====================================

Name: keypad_time_loader

Overview:
Sequential consumer of the keypad priority encoder's D/valid output. Edge-detects each key press and shifts BCD digits into a 4-digit MM:SS entry buffer. Arbitrates clear/start/door/timer events, presents the entered time and a one-cycle load strobe to the countdown timer, and drives the encoder's enable (keypad lock) while a cook cycle is active or paused.

Parameters:
QUICK_START_BCD, 16'h0030, time loaded when start is pressed with an empty buffer (MM:SS BCD, 00:30)
SEC_TENS_MAX, 5, largest legal seconds-tens digit at start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
D  in  4  digit code from priority encoder
valid  in  1  encoder valid; high while exactly one legal key is held
clear  in  1  clear/cancel button level, synchronous to clk
start  in  1  start button level, synchronous to clk
door_closed  in  1  door sensor, 1 = closed
timer_done  in  1  one-cycle pulse from countdown timer at 00:00
time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}
digit_count  out  3  digits entered, 0..4
load  out  1  one-cycle strobe: timer captures time_bcd
lock  out  1  to encoder enable; 1 = keypad ignored
run  out  1  1 = magnetron/timer counting
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async, rst_n=0): state IDLE; time_bcd=0, digit_count=0, load=0, lock=0, run=0, err=0; edge registers valid_q, start_q, clear_q = 0.
- Edge detect: key_ev = valid & ~valid_q; start_ev = start & ~start_q; clear_ev = clear & ~clear_q. Registered outputs; each event takes effect on the clock edge after detection (1-cycle latency).
- Priority in the same cycle: clear_ev > timer_done > start_ev > key_ev. Lower-priority events in that cycle are dropped, not queued.
- States: IDLE (buffer empty), ENTRY (1..4 digits), COOK (run=1, lock=1), PAUSE (run=0, lock=1).
- key_ev in IDLE/ENTRY with D<=9 and digit_count<4: shift left one digit, new digit into sec_ones, digit_count+1, state ENTRY. D>9, digit_count=4, or state COOK/PAUSE: ignored, no change.
- Entered value 0 (e.g. key 0 pressed alone) counts as a digit: ENTRY with time_bcd=0.
- start_ev in IDLE, door_closed=1: time_bcd=QUICK_START_BCD, load=1, → COOK.
- start_ev in ENTRY, door_closed=1: if sec_tens>SEC_TENS_MAX or time_bcd==0, err=1 and stay in ENTRY with buffer kept. Otherwise load=1, → COOK.
- start_ev with door_closed=0 in IDLE/ENTRY: err=1, no other change.
- COOK: door_closed=0 → PAUSE (run=0 same edge). timer_done → IDLE, time_bcd=0, digit_count=0, lock=0, run=0.
- PAUSE: start_ev with door_closed=1 → COOK, no load (timer resumes its own count). start_ev with door open → err=1.
- clear_ev: from ENTRY/IDLE → IDLE with buffer zeroed. From COOK/PAUSE → IDLE, run=0, lock=0, buffer zeroed (abort).
- load and err are high for exactly one cycle. Held buttons never retrigger.
- lock=1 exactly in COOK and PAUSE.
- timer_done outside COOK: ignored.
- time_bcd stays stable during COOK/PAUSE.

Decomposition:
- Shared package microwave_pkg: state enum {IDLE, ENTRY, COOK, PAUSE}, BCD digit width 4, MAX_DIGITS=4, key code KEY_MAX=4'd9.
- One natural sub-module: edge_detect (1-bit rising-edge detector with async active-low reset), instantiated three times for valid, start and clear.

Test Plan:
- Press 1,2,3,0 (valid pulses of 3 cycles each) → time_bcd=16'h1230, digit_count=4. A fifth key 5 → unchanged.
- Start with buffer 16'h1230, door closed → load pulse 1 cycle, run=1, lock=1. Assert timer_done → IDLE, time_bcd=0, lock=0.
- Empty buffer, start → time_bcd=16'h0030, load=1, COOK.
- Enter 1,7,5 (16'h0175), start → err=1, state ENTRY, buffer kept. Start with door open on 16'h0130 → err=1.
- COOK, door_closed=0 → run=0, lock=1. Start with door closed → run=1, no load. Clear asserted in the same cycle as start → IDLE, all zero.
- Hold valid for 20 cycles → one digit only. D=4'hA with valid → ignored. rst_n low mid-COOK → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave keypad/time-entry slice.
//   state_e    : loader FSM states (IDLE, ENTRY, COOK, PAUSE)
//   DIGIT_W    : width of one BCD digit
//   MAX_DIGITS : digits held by the MM:SS entry buffer
//   KEY_MAX    : largest encoder code that is a numeric key
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        COOK  = 2'd2,
        PAUSE = 2'd3
    } state_e;

    localparam int          DIGIT_W    = 4;
    localparam int          MAX_DIGITS = 4;
    localparam logic [3:0]  KEY_MAX    = 4'd9;

    // Shift the MM:SS buffer one digit left and append the new key as sec_ones.
    function automatic logic [15:0] shift_in_digit(input logic [15:0] buf_bcd,
                                                   input logic [DIGIT_W-1:0] digit);
        return {buf_bcd[15-DIGIT_W:0], digit};
    endfunction

endpackage

// File: rtl/keypad_time_loader_if.sv
// Bus between the keypad/button front end and the time loader.
//   Inputs to loader : D, valid, clear, start, door_closed, timer_done
//   Outputs of loader: time_bcd, digit_count, load, lock, run, err
//   master modport   : drives the inputs (encoder, buttons, timer side)
//   slave modport    : the loader itself
interface keypad_time_loader_if;
    import microwave_pkg::*;

    logic [DIGIT_W-1:0] D;
    logic               valid;
    logic               clear;
    logic               start;
    logic               door_closed;
    logic               timer_done;
    logic [15:0]        time_bcd;
    logic [2:0]         digit_count;
    logic               load;
    logic               lock;
    logic               run;
    logic               err;

    modport master (
        output D, valid, clear, start, door_closed, timer_done,
        input  time_bcd, digit_count, load, lock, run, err
    );

    modport slave (
        input  D, valid, clear, start, door_closed, timer_done,
        output time_bcd, digit_count, load, lock, run, err
    );

endinterface

// File: rtl/keypad_time_loader_edge_detect.sv
// 1-bit rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig_i      : level input, synchronous to clk
//   rise_o     : high in the cycle where sig_i is 1 and was 0 last cycle
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/keypad_time_loader.sv
// Keypad time loader: turns encoder key presses into an MM:SS BCD entry,
// arbitrates clear/start/door/timer events and drives the countdown timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.D/valid                 : encoder digit code and valid level
//   bus.clear/start             : button levels (edge-detected here)
//   bus.door_closed             : door sensor, 1 = closed
//   bus.timer_done              : one-cycle pulse from the countdown timer
//   bus.time_bcd/digit_count    : entry buffer and number of digits entered
//   bus.load                    : one-cycle strobe, timer captures time_bcd
//   bus.lock                    : keypad lock (encoder enable), COOK/PAUSE
//   bus.run                     : timer counting, COOK only
//   bus.err                     : one-cycle pulse on a rejected start
module keypad_time_loader
    import microwave_pkg::*;
#(
    parameter logic [15:0] QUICK_START_BCD = 16'h0030,
    parameter logic [3:0]  SEC_TENS_MAX    = 4'd5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keypad_time_loader_if.slave  bus
);

    logic key_ev;
    logic start_ev;
    logic clear_ev;

    edge_detect u_valid_edge (.clk(clk), .rst_n(rst_n), .sig_i(bus.valid), .rise_o(key_ev));
    edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .sig_i(bus.start), .rise_o(start_ev));
    edge_detect u_clear_edge (.clk(clk), .rst_n(rst_n), .sig_i(bus.clear), .rise_o(clear_ev));

    state_e      state_q, state_d;
    logic [15:0] time_q,  time_d;
    logic [2:0]  count_q, count_d;
    logic        load_q,  load_d;
    logic        err_q,   err_d;
    logic        run_q,   run_d;
    logic        lock_q,  lock_d;

    logic entry_bad;
    assign entry_bad = (time_q[7:4] > SEC_TENS_MAX) || (time_q == 16'h0000);

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        time_d  = time_q;
        count_d = count_q;
        load_d  = 1'b0;
        err_d   = 1'b0;

        // One event per cycle, highest priority wins; the rest are dropped.
        if (clear_ev) begin
            state_d = IDLE;
            time_d  = '0;
            count_d = '0;
        end else if (bus.timer_done && state_q == COOK) begin
            state_d = IDLE;
            time_d  = '0;
            count_d = '0;
        end else if (start_ev) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.door_closed) begin
                        time_d  = QUICK_START_BCD;
                        load_d  = 1'b1;
                        state_d = COOK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ENTRY: begin
                    if (!bus.door_closed || entry_bad) begin
                        err_d = 1'b1;
                    end else begin
                        load_d  = 1'b1;
                        state_d = COOK;
                    end
                end
                PAUSE: begin
                    // Resume: the timer still holds its own remaining count.
                    if (bus.door_closed) begin
                        state_d = COOK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;  // COOK: already running
            endcase
        end else if (key_ev && (state_q == IDLE || state_q == ENTRY)
                     && bus.D <= KEY_MAX && count_q < 3'(MAX_DIGITS)) begin
            time_d  = shift_in_digit(time_q, bus.D);
            count_d = count_q + 3'd1;
            state_d = ENTRY;
        end

        // Door opening is a level condition, not an arbitrated event.
        if (state_q == COOK && state_d == COOK && !bus.door_closed) begin
            state_d = PAUSE;
        end

        run_d  = (state_d == COOK);
        lock_d = (state_d == COOK) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            count_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            count_q <= count_d;
            load_q  <= load_d;
            err_q   <= err_d;
            run_q   <= run_d;
            lock_q  <= lock_d;
        end
    end

    assign bus.time_bcd    = time_q;
    assign bus.digit_count = count_q;
    assign bus.load        = load_q;
    assign bus.err         = err_q;
    assign bus.run         = run_q;
    assign bus.lock        = lock_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed self-checking bench for keypad_time_loader.
module tb_keypad_time_loader;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    keypad_time_loader_if bus ();

    keypad_time_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        bus.D     = d;
        bus.valid = 1'b1;
        repeat (3) step();
        bus.valid = 1'b0;
        step();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
    endtask

    task automatic check_outs(input string tag, input logic [15:0] t, input logic [2:0] c,
                              input logic ld, input logic lk, input logic rn, input logic er);
        check({tag, ".time"},  32'(bus.time_bcd),    32'(t));
        check({tag, ".count"}, 32'(bus.digit_count), 32'(c));
        check({tag, ".load"},  32'(bus.load),        32'(ld));
        check({tag, ".lock"},  32'(bus.lock),        32'(lk));
        check({tag, ".run"},   32'(bus.run),         32'(rn));
        check({tag, ".err"},   32'(bus.err),         32'(er));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.D = 4'd0; bus.valid = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
        bus.door_closed = 1'b1; bus.timer_done = 1'b0;

        repeat (2) step();
        check_outs("reset", 16'h0000, 3'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        // Four digits, then a fifth that must be ignored.
        press_key(4'd1);
        check_outs("key1", 16'h0001, 3'd1, 0, 0, 0, 0);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd0);
        check_outs("key1230", 16'h1230, 3'd4, 0, 0, 0, 0);
        press_key(4'd5);
        check_outs("key5th", 16'h1230, 3'd4, 0, 0, 0, 0);

        // Start with full buffer; held start must not retrigger.
        bus.start = 1'b1;
        step();
        check_outs("start1230", 16'h1230, 3'd4, 1, 1, 1, 0);
        step();
        check_outs("start_held", 16'h1230, 3'd4, 0, 1, 1, 0);
        bus.start = 1'b0;
        step();
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
        check_outs("timer_done", 16'h0000, 3'd0, 0, 0, 0, 0);

        // Quick start from an empty buffer.
        bus.start = 1'b1;
        step();
        check_outs("quick", 16'h0030, 3'd0, 1, 1, 1, 0);
        bus.start = 1'b0;
        step();
        do_clear();
        check_outs("clear_cook", 16'h0000, 3'd0, 0, 0, 0, 0);

        // Seconds-tens of 7 is rejected, buffer kept.
        press_key(4'd1);
        press_key(4'd7);
        press_key(4'd5);
        check_outs("key175", 16'h0175, 3'd3, 0, 0, 0, 0);
        bus.start = 1'b1;
        step();
        check_outs("err175", 16'h0175, 3'd3, 0, 0, 0, 1);
        step();
        check("err175_pulse", 32'(bus.err), 32'd0);
        bus.start = 1'b0;
        step();

        // Door open on a valid entry.
        do_clear();
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd0);
        bus.door_closed = 1'b0;
        bus.start = 1'b1;
        step();
        check_outs("err_door", 16'h0130, 3'd3, 0, 0, 0, 1);
        bus.start = 1'b0;
        step();

        // Cook, pause on door, resume without load.
        bus.door_closed = 1'b1;
        bus.start = 1'b1;
        step();
        check_outs("cook130", 16'h0130, 3'd3, 1, 1, 1, 0);
        bus.start = 1'b0;
        step();
        bus.door_closed = 1'b0;
        step();
        check_outs("pause", 16'h0130, 3'd3, 0, 1, 0, 0);
        bus.start = 1'b1;
        step();
        check_outs("pause_err", 16'h0130, 3'd3, 0, 1, 0, 1);
        bus.start = 1'b0;
        bus.door_closed = 1'b1;
        step();
        check_outs("pause_closed", 16'h0130, 3'd3, 0, 1, 0, 0);
        bus.start = 1'b1;
        step();
        check_outs("resume", 16'h0130, 3'd3, 0, 1, 1, 0);
        bus.start = 1'b0;
        step();
        // Keys are ignored while cooking.
        press_key(4'd4);
        check_outs("cook_key", 16'h0130, 3'd3, 0, 1, 1, 0);
        // Clear beats start in the same cycle.
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step();
        check_outs("clear_start", 16'h0000, 3'd0, 0, 0, 0, 0);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        step();

        // Held key gives one digit; non-numeric code ignored.
        bus.D = 4'd8;
        bus.valid = 1'b1;
        repeat (20) step();
        bus.valid = 1'b0;
        step();
        check_outs("hold", 16'h0008, 3'd1, 0, 0, 0, 0);
        press_key(4'hA);
        check_outs("keyA", 16'h0008, 3'd1, 0, 0, 0, 0);
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
        check_outs("td_idle", 16'h0008, 3'd1, 0, 0, 0, 0);

        // A lone zero is a digit, but starting it is rejected.
        do_clear();
        press_key(4'd0);
        check_outs("key0", 16'h0000, 3'd1, 0, 0, 0, 0);
        bus.start = 1'b1;
        step();
        check_outs("err_zero", 16'h0000, 3'd1, 0, 0, 0, 1);
        bus.start = 1'b0;
        step();

        // Asynchronous reset mid-cook.
        press_key(4'd2);
        bus.start = 1'b1;
        step();
        check_outs("cook02", 16'h0002, 3'd2, 1, 1, 1, 0);
        bus.start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 16'h0000, 3'd0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
